// File: rtl/umi_fifo_pkg.sv
// Shared types and helpers for the UMI request FIFO.
package umi_fifo_pkg;

  localparam int unsigned UMI_DW = 32;
  localparam int unsigned UMI_CW = 32;
  localparam int unsigned UMI_AW = 64;

  // One buffered request packet, command in the most significant bits.
  typedef struct packed {
    logic [UMI_CW-1:0] cmd;
    logic [UMI_AW-1:0] dstaddr;
    logic [UMI_AW-1:0] srcaddr;
    logic [UMI_DW-1:0] data;
  } umi_pkt_t;

  // Pointer wrap relies on a power-of-two depth; a single entry cannot decouple.
  function automatic bit depth_legal(int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/umi_req_fifo_if.sv
// UMI request channel: valid/ready handshake plus packet fields.
// master drives the packet, slave returns ready.
interface umi_req_fifo_if
  import umi_fifo_pkg::*;
#(
  parameter int unsigned DW = UMI_DW,
  parameter int unsigned CW = UMI_CW,
  parameter int unsigned AW = UMI_AW
) ();

  logic          valid;
  logic [CW-1:0] cmd;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
  modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);

endinterface

// File: rtl/umi_fifo_mem.sv
// Flop-array packet storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module umi_fifo_mem
  import umi_fifo_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = $bits(umi_pkt_t)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem_q [Depth];

  // Capture the pushed packet into its slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/umi_req_fifo.sv
// Registered first-word-fall-through FIFO between a host-side UMI requester
// and a device endpoint request input. Occupancy is exported on count.
// Optional feature: define UMI_REQ_FIFO_HWM_EN to add the hwm output
// (maximum occupancy since reset).
module umi_req_fifo
  import umi_fifo_pkg::*;
#(
  parameter int unsigned DW    = UMI_DW,
  parameter int unsigned CW    = UMI_CW,
  parameter int unsigned AW    = UMI_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  umi_req_fifo_if.slave                host_req,
  umi_req_fifo_if.master               udev_req,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef UMI_REQ_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned PW   = CW + 2 * AW + DW;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_depth_err
    $error("umi_req_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q, ready_d;
  logic            valid;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_pkt;
  logic [PW-1:0]   rd_pkt;

  // Full/empty come from the count so pointers can wrap freely.
  assign valid = (count_q != '0);
  assign push  = host_req.valid & ready_q;
  assign pop   = valid & udev_req.ready;

  // Next pointers, occupancy and ready; ready is registered so a pop at full
  // only reopens the input on the following cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != Full);
  end

  // Control state; ready stays low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign wr_pkt = {host_req.cmd, host_req.dstaddr, host_req.srcaddr, host_req.data};

  umi_fifo_mem #(
    .Depth (DEPTH),
    .Width (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_pkt),
    .raddr (rd_ptr_q),
    .rdata (rd_pkt)
  );

  // Stale storage is masked so an empty FIFO presents an all-zero packet.
  assign {udev_req.cmd, udev_req.dstaddr, udev_req.srcaddr, udev_req.data} =
      valid ? rd_pkt : '0;
  assign udev_req.valid = valid;
  assign host_req.ready = ready_q;
  assign count          = count_q;

`ifdef UMI_REQ_FIFO_HWM_EN
  logic [CntW-1:0] hwm_q;

  // Track peak occupancy; lags count by one cycle and never exceeds DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_q <= '0;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_umi_req_fifo.sv
// Bench for umi_req_fifo: directed DEPTH=4 sequences checked against a
// queue model every cycle, plus random scoreboard runs at DEPTH=2 and 8.
`timescale 1ns/1ps
module tb_umi_req_fifo;
  import umi_fifo_pkg::*;

  localparam int unsigned Depth       = 4;
  localparam int unsigned CntW        = $clog2(Depth + 1);
  localparam int          NumRandPkts = 10000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main DUT ----------------
  umi_req_fifo_if host_if ();
  umi_req_fifo_if udev_if ();
  logic [CntW-1:0] count;
`ifdef UMI_REQ_FIFO_HWM_EN
  logic [CntW-1:0] hwm;
`endif

  umi_req_fifo #(
    .DEPTH (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .host_req (host_if),
    .udev_req (udev_if),
    .count    (count)
`ifdef UMI_REQ_FIFO_HWM_EN
    ,
    .hwm      (hwm)
`endif
  );

  // Behavioural model: a packet queue, a registered ready flag and a peak tracker.
  umi_pkt_t        model_q[$];
  logic            exp_ready = 1'b0;
  logic [CntW-1:0] exp_hwm   = '0;

  always @(posedge clk or posedge reset) begin : model
    int  old_size;
    int  new_size;
    bit  do_push;
    bit  do_pop;
    umi_pkt_t in_pkt;
    if (reset) begin
      model_q.delete();
      exp_ready <= 1'b0;
      exp_hwm   <= '0;
    end else begin
      old_size = model_q.size();
      do_push  = host_if.valid && exp_ready;
      do_pop   = (old_size != 0) && udev_if.ready;
      in_pkt   = {host_if.cmd, host_if.dstaddr, host_if.srcaddr, host_if.data};
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(in_pkt);
      new_size = model_q.size();
      if (old_size > int'(exp_hwm)) exp_hwm <= CntW'(old_size);
      exp_ready <= (new_size != Depth);
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin : compare
    umi_pkt_t exp_pkt;
    umi_pkt_t act_pkt;
    exp_pkt = (model_q.size() != 0) ? model_q[0] : '0;
    act_pkt = {udev_if.cmd, udev_if.dstaddr, udev_if.srcaddr, udev_if.data};
    check("host_req_ready", host_if.ready, exp_ready);
    check("udev_req_valid", udev_if.valid, model_q.size() != 0);
    check("count", count, model_q.size());
    check("udev_req_payload", act_pkt, exp_pkt);
`ifdef UMI_REQ_FIFO_HWM_EN
    check("hwm", hwm, exp_hwm);
`endif
  end

  task automatic drive_pkt(input logic [31:0] d);
    host_if.cmd     = d ^ 32'hA5A5_0000;
    host_if.dstaddr = {32'hD000_0000, d};
    host_if.srcaddr = {32'h5000_0000, d};
    host_if.data    = d;
  endtask

  // Offer one packet for up to max_cycles; ok reports whether it was taken.
  task automatic push_pkt(input logic [31:0] d, input int max_cycles, output bit ok);
    drive_pkt(d);
    host_if.valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      ok = host_if.ready;
      tick();
    end
    host_if.valid = 1'b0;
  endtask

  initial begin : directed
    bit ok;
    host_if.valid = 1'b0;
    drive_pkt(32'h0);
    udev_if.ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", host_if.ready, 1'b0);
    check("rst_valid", udev_if.valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_data", udev_if.data, 32'h0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", host_if.ready, 1'b1);

    // Reset mid-burst with three packets buffered
    for (int i = 1; i <= 3; i++) push_pkt(32'h10 + i, 4, ok);
    check("midburst_count", count, 3);
    drive_pkt(32'h14);
    host_if.valid = 1'b1;
    reset = 1'b1;
    tick();
    check("midrst_count", count, 0);
    check("midrst_valid", udev_if.valid, 1'b0);
    check("midrst_ready", host_if.ready, 1'b0);
    host_if.valid = 1'b0;
    reset = 1'b0;
    tick();
    check("midrst_ready_release", host_if.ready, 1'b1);
    check("midrst_count_release", count, 0);

    // Fill with the device stalled; the fifth packet must be held off
    for (int i = 1; i <= 4; i++) begin
      push_pkt(i, 4, ok);
      check("fill_accept", ok, 1'b1);
    end
    check("fill_ready", host_if.ready, 1'b0);
    check("fill_count", count, 4);
    push_pkt(5, 3, ok);
    check("fill_pkt5_held", ok, 1'b0);
    check("fill_count_hold", count, 4);

    // Drain in order on consecutive cycles
    udev_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", udev_if.valid, 1'b1);
      check("drain_data", udev_if.data, i);
      tick();
    end
    check("drain_empty_valid", udev_if.valid, 1'b0);
    check("drain_empty_count", count, 0);
    udev_if.ready = 1'b0;

    // Full with simultaneous push and pop: only the pop happens
    for (int i = 1; i <= 4; i++) push_pkt(32'h20 + i, 4, ok);
    drive_pkt(32'h25);
    host_if.valid = 1'b1;
    udev_if.ready = 1'b1;
    tick();
    host_if.valid = 1'b0;
    udev_if.ready = 1'b0;
    check("fullpop_count", count, 3);
    check("fullpop_ready", host_if.ready, 1'b1);
    check("fullpop_head", udev_if.data, 32'h22);
    udev_if.ready = 1'b1;
    repeat (3) tick();
    udev_if.ready = 1'b0;
    check("fullpop_drained", count, 0);

    // Streaming: one packet per cycle at steady occupancy 1
    udev_if.ready = 1'b1;
    host_if.valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_pkt(32'h1000 + i);
      tick();
      check("stream_count", count, 1);
      check("stream_data", udev_if.data, 32'h1000 + i);
    end
    host_if.valid = 1'b0;
    tick();
    check("stream_end_count", count, 0);
    udev_if.ready = 1'b0;

`ifdef UMI_REQ_FIFO_HWM_EN
    // High-water mark
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("hwm_rst", hwm, 0);
    for (int i = 1; i <= 3; i++) push_pkt(32'h30 + i, 4, ok);
    udev_if.ready = 1'b1;
    repeat (3) tick();
    udev_if.ready = 1'b0;
    push_pkt(32'h34, 4, ok);
    tick();
    check("hwm_three", hwm, 3);
    for (int i = 5; i <= 7; i++) push_pkt(32'h30 + i, 4, ok);
    tick();
    check("hwm_four", hwm, 4);
    reset = 1'b1;
    #1;
    check("hwm_cleared", hwm, 0);
    tick();
    reset = 1'b0;
    tick();
`endif

    // Wait for the random runs, bounded
    for (int i = 0; i < 70000 && !(g_rand[0].done && g_rand[1].done); i++) @(posedge clk);
    check("rand_runs_done", {g_rand[1].done, g_rand[0].done}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- random scoreboard runs ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int unsigned D  = (g == 0) ? 2 : 8;
    localparam int unsigned CR = $clog2(D + 1);

    umi_req_fifo_if rh ();
    umi_req_fifo_if ru ();
    logic [CR-1:0] rcnt;
`ifdef UMI_REQ_FIFO_HWM_EN
    logic [CR-1:0] rhwm;
`endif
    logic rrst = 1'b1;
    bit   done = 1'b0;

    umi_req_fifo #(
      .DEPTH (D)
    ) u_dut (
      .clk      (clk),
      .reset    (rrst),
      .host_req (rh),
      .udev_req (ru),
      .count    (rcnt)
`ifdef UMI_REQ_FIFO_HWM_EN
      ,
      .hwm      (rhwm)
`endif
    );

    initial begin : stim
      umi_pkt_t    sb[$];
      umi_pkt_t    act;
      umi_pkt_t    prev_head;
      umi_pkt_t    in_pkt;
      bit          prev_stall;
      bit          pushed;
      bit          popped_now;
      int          popped;
      logic [31:0] seq;
      rh.valid = 1'b0;
      rh.cmd = '0;
      rh.dstaddr = '0;
      rh.srcaddr = '0;
      rh.data = '0;
      ru.ready = 1'b0;
      seq = 0;
      popped = 0;
      prev_stall = 1'b0;
      prev_head = '0;
      tick();
      tick();
      rrst = 1'b0;
      for (int cyc = 0; cyc < 60000 && popped < NumRandPkts; cyc++) begin
        @(negedge clk);
        act = {ru.cmd, ru.dstaddr, ru.srcaddr, ru.data};
        check("rand_count", rcnt, sb.size());
        check("rand_valid", ru.valid, sb.size() != 0);
        if (prev_stall) begin
          check("rand_stall_valid", ru.valid, 1'b1);
          check("rand_stall_payload", act, prev_head);
        end
        pushed     = rh.valid && rh.ready;
        popped_now = ru.valid && ru.ready;
        check("rand_no_push_full", pushed && (sb.size() >= D), 1'b0);
        check("rand_no_pop_empty", popped_now && (sb.size() == 0), 1'b0);
        if (popped_now && sb.size() != 0) begin
          check("rand_order", act, sb[0]);
          void'(sb.pop_front());
          popped++;
        end
        if (pushed) begin
          in_pkt = {rh.cmd, rh.dstaddr, rh.srcaddr, rh.data};
          sb.push_back(in_pkt);
        end
        prev_stall = ru.valid && !ru.ready;
        prev_head  = act;
        tick();
        if (!rh.valid || pushed) begin
          rh.valid = ($urandom_range(3) != 0);
          if (rh.valid) begin
            rh.cmd     = $urandom;
            rh.dstaddr = {$urandom, $urandom};
            rh.srcaddr = {$urandom, $urandom};
            rh.data    = seq;
            seq++;
          end
        end
        ru.ready = ($urandom_range(3) != 0);
      end
      check("rand_all_popped", popped, NumRandPkts);
      rh.valid = 1'b0;
      ru.ready = 1'b0;
      done = 1'b1;
    end
  end

endmodule
